// File: rtl/blitter_pkg.sv
// ============================================================================
// Module   : blitter_pkg
// Purpose  : Shared state encoding and default constants for sprite_blitter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package blitter_pkg;
   typedef logic [1:0] blit_state_t;

   localparam blit_state_t ST_IDLE   = 2'd0;
   localparam blit_state_t ST_CLEAR  = 2'd1;
   localparam blit_state_t ST_SPRITE = 2'd2;
   localparam blit_state_t ST_FINISH = 2'd3;

   localparam int         DEF_H_RES    = 640;
   localparam int         DEF_V_RES    = 480;
   localparam int         DEF_ADDR_W   = 19;
   localparam logic [7:0] DEF_BG_COLOR = 8'b1110_0000;

   localparam int POS_W = 10;  // sprite coordinate width
   localparam int CNT_W = 16;  // scan counter width
endpackage

`default_nettype wire

// File: rtl/rect_scan.sv
// ============================================================================
// Module   : rect_scan
// Purpose  : 2-D raster counter, x inner / y outer, with last-pixel flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rect_scan
   import blitter_pkg::*;
#(
   parameter int CW = CNT_W
) (
   input  logic          i_clk,
   input  logic          i_r,
   input  logic          i_load,
   input  logic          i_step,
   input  logic [CW-1:0] i_width,
   input  logic [CW-1:0] i_height,
   output logic [CW-1:0] o_x,
   output logic [CW-1:0] o_y,
   output logic          o_last
);
   logic [CW-1:0] r_x;
   logic [CW-1:0] r_y;
   logic          w_x_end;
   logic          w_y_end;

   assign w_x_end = (r_x == i_width - 1'b1);
   assign w_y_end = (r_y == i_height - 1'b1);
   assign o_last  = w_x_end & w_y_end;
   assign o_x     = r_x;
   assign o_y     = r_y;

   always_ff @(posedge i_clk or posedge i_r) begin
      if (i_r) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_load) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_step) begin
         if (w_x_end) begin
            r_x <= '0;
            r_y <= w_y_end ? '0 : r_y + 1'b1;
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/sprite_blitter.sv
// ============================================================================
// Module   : sprite_blitter
// Purpose  : Frame-buffer writer: optional background clear, then NUM_SPR
//            clipped solid sprites, one pixel per clock.
//            Define SPRITE_BLITTER_CLEAR_EN to compile in the clear pass.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_blitter
   import blitter_pkg::*;
#(
   parameter int                 H_RES    = DEF_H_RES,
   parameter int                 V_RES    = DEF_V_RES,
   parameter int                 ADDR_W   = DEF_ADDR_W,
   parameter int                 COLOR_W  = 8,
   parameter int                 SPR_W    = 10,
   parameter int                 SPR_H    = 10,
   parameter int                 NUM_SPR  = 4,
   parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(DEF_BG_COLOR)
) (
   input  logic                       i_clk,
   input  logic                       i_r,
   input  logic                       i_start,
   input  logic [NUM_SPR*POS_W-1:0]   i_sprite_x,
   input  logic [NUM_SPR*POS_W-1:0]   i_sprite_y,
   input  logic [NUM_SPR-1:0]         i_sprite_en,
   input  logic [NUM_SPR*COLOR_W-1:0] i_sprite_color,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_we,
   output logic [ADDR_W-1:0]          o_addr,
   output logic [COLOR_W-1:0]         o_color
);
`ifdef SPRITE_BLITTER_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif
   localparam int SW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

   blit_state_t                r_state;
   logic [SW-1:0]              r_slot;
   logic [NUM_SPR*POS_W-1:0]   r_spr_x;
   logic [NUM_SPR*POS_W-1:0]   r_spr_y;
   logic [NUM_SPR-1:0]         r_spr_en;
   logic [NUM_SPR*COLOR_W-1:0] r_spr_color;
   logic                       r_busy, r_done, r_we;
   logic [ADDR_W-1:0]          r_addr;
   logic [COLOR_W-1:0]         r_color;

   logic                       w_idle, w_accept, w_emit, w_clear_mode, w_last;
   logic [CNT_W-1:0]           w_width, w_height, w_x, w_y;
   logic [NUM_SPR*POS_W-1:0]   w_src_x, w_src_y;
   logic [NUM_SPR-1:0]         w_src_en;
   logic [NUM_SPR*COLOR_W-1:0] w_src_color;
   logic [POS_W-1:0]           w_sx, w_sy;
   logic [10:0]                w_px, w_py;
   logic                       w_en, w_in_frame;
   logic                       w_pix_we;
   logic [ADDR_W-1:0]          w_pix_addr;
   logic [COLOR_W-1:0]         w_pix_color;

   // r_done blocks a restart in the same cycle that done is visible
   assign w_idle       = (r_state == ST_IDLE);
   assign w_accept     = w_idle && i_start && !r_done;
   assign w_emit       = w_accept || (r_state == ST_CLEAR) || (r_state == ST_SPRITE);
   assign w_clear_mode = (r_state == ST_CLEAR) || (w_idle && CLEAR_EN);
   assign w_width      = w_clear_mode ? CNT_W'(H_RES) : CNT_W'(SPR_W);
   assign w_height     = w_clear_mode ? CNT_W'(V_RES) : CNT_W'(SPR_H);

   rect_scan #(.CW(CNT_W)) u_scan (
      .i_clk    (i_clk),
      .i_r      (i_r),
      .i_load   (w_emit && w_last),
      .i_step   (w_emit && !w_last),
      .i_width  (w_width),
      .i_height (w_height),
      .o_x      (w_x),
      .o_y      (w_y),
      .o_last   (w_last)
   );

   // The first pixel is emitted in the start cycle, before the shadows load
   assign w_src_x     = w_idle ? i_sprite_x     : r_spr_x;
   assign w_src_y     = w_idle ? i_sprite_y     : r_spr_y;
   assign w_src_en    = w_idle ? i_sprite_en    : r_spr_en;
   assign w_src_color = w_idle ? i_sprite_color : r_spr_color;

   assign w_sx       = w_src_x[r_slot*POS_W +: POS_W];
   assign w_sy       = w_src_y[r_slot*POS_W +: POS_W];
   assign w_en       = w_src_en[r_slot];
   assign w_px       = {1'b0, w_sx} + 11'(w_x);
   assign w_py       = {1'b0, w_sy} + 11'(w_y);
   assign w_in_frame = ({21'd0, w_px} < H_RES) && ({21'd0, w_py} < V_RES);

   always_comb begin
      w_pix_we    = 1'b0;
      w_pix_addr  = '0;
      w_pix_color = '0;
      if (w_clear_mode) begin
         w_pix_we    = 1'b1;
         w_pix_addr  = ADDR_W'(w_y) * ADDR_W'(H_RES) + ADDR_W'(w_x);
         w_pix_color = BG_COLOR;
      end else if (w_en && w_in_frame) begin
         w_pix_we    = 1'b1;
         w_pix_addr  = ADDR_W'(w_py) * ADDR_W'(H_RES) + ADDR_W'(w_px);
         w_pix_color = w_src_color[r_slot*COLOR_W +: COLOR_W];
      end
   end

   always_ff @(posedge i_clk or posedge i_r) begin
      if (i_r) begin
         r_state     <= ST_IDLE;
         r_slot      <= '0;
         r_spr_x     <= '0;
         r_spr_y     <= '0;
         r_spr_en    <= '0;
         r_spr_color <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_color     <= '0;
      end else begin
         r_done  <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_color <= '0;
         if (w_accept) begin
            r_spr_x     <= i_sprite_x;
            r_spr_y     <= i_sprite_y;
            r_spr_en    <= i_sprite_en;
            r_spr_color <= i_sprite_color;
         end
         case (r_state)
            ST_FINISH: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               if (w_emit) begin
                  r_busy  <= 1'b1;
                  r_we    <= w_pix_we;
                  r_addr  <= w_pix_addr;
                  r_color <= w_pix_color;
                  if (!w_last) begin
                     r_state <= w_clear_mode ? ST_CLEAR : ST_SPRITE;
                  end else if (w_clear_mode) begin
                     r_state <= ST_SPRITE;
                  end else if (r_slot == SW'(NUM_SPR - 1)) begin
                     r_state <= ST_FINISH;
                     r_slot  <= '0;
                  end else begin
                     r_slot  <= r_slot + 1'b1;
                     r_state <= ST_SPRITE;
                  end
               end
            end
         endcase
      end
   end

   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_we    = r_we;
   assign o_addr  = r_addr;
   assign o_color = r_color;
endmodule

`default_nettype wire

// File: tb/tb_sprite_blitter.sv
// ============================================================================
// Module   : tb_sprite_blitter
// Purpose  : Scoreboard bench for sprite_blitter on an 8x4 frame, two 2x2 sprites.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sprite_blitter;
   localparam int         H  = 8;
   localparam int         V  = 4;
   localparam int         SW = 2;
   localparam int         SH = 2;
   localparam int         N  = 2;
   localparam int         AW = 5;
   localparam logic [7:0] BG = 8'hE0;
`ifdef SPRITE_BLITTER_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   typedef struct {
      int cyc;
      bit busy;
      bit we;
      int addr;
      int color;
      bit done;
   } exp_t;

   logic          clk = 1'b0;
   logic          i_r;
   logic          i_start;
   logic [N*10-1:0] i_sprite_x, i_sprite_y;
   logic [N-1:0]  i_sprite_en;
   logic [N*8-1:0] i_sprite_color;
   logic          o_busy, o_done, o_we;
   logic [AW-1:0] o_addr;
   logic [7:0]    o_color;

   exp_t q[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   fb_dut[H*V];
   int   fb_exp[H*V];
   bit   fb_known[H*V];
   int   f_x[N], f_y[N], f_col[N];
   bit   f_en[N];

   sprite_blitter #(
      .H_RES(H), .V_RES(V), .ADDR_W(AW), .COLOR_W(8),
      .SPR_W(SW), .SPR_H(SH), .NUM_SPR(N), .BG_COLOR(BG)
   ) dut (
      .i_clk(clk), .i_r(i_r), .i_start(i_start),
      .i_sprite_x(i_sprite_x), .i_sprite_y(i_sprite_y),
      .i_sprite_en(i_sprite_en), .i_sprite_color(i_sprite_color),
      .o_busy(o_busy), .o_done(o_done), .o_we(o_we),
      .o_addr(o_addr), .o_color(o_color)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected picture after a finished frame: topmost enabled sprite covering
   // a pixel, else background (clear build) or unchanged content.
   task automatic frame_picture_check();
      int bad = 0;
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            int c = -1;
            for (int k = 0; k < N; k++)
               if (f_en[k] && x >= f_x[k] && x < f_x[k] + SW && y >= f_y[k] && y < f_y[k] + SH)
                  c = f_col[k];
            if (c >= 0) begin
               fb_exp[y*H+x] = c;
               fb_known[y*H+x] = 1'b1;
            end else if (CLR) begin
               fb_exp[y*H+x] = BG;
               fb_known[y*H+x] = 1'b1;
            end
            if (fb_known[y*H+x] && fb_exp[y*H+x] != fb_dut[y*H+x]) bad++;
         end
      end
      chk("picture_mismatched_pixels", bad, 0);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
         exp_t e;
         e = q.pop_front();
         chk("busy", o_busy, e.busy);
         chk("we", o_we, e.we);
         chk("addr", o_addr, e.addr);
         chk("color", o_color, e.color);
         chk("done", o_done, e.done);
         if (o_we === 1'b1) fb_dut[o_addr] = o_color;
         if (e.done) frame_picture_check();
      end else begin
         if (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missed_expected_cycle", cyc, q[0].cyc);
            void'(q.pop_front());
         end
         chk("idle_outputs", {o_busy, o_we, o_done, o_addr, o_color}, 0);
         if (o_we === 1'b1) fb_dut[o_addr] = o_color;
      end
   end

   task automatic scramble();
      i_sprite_x     = N*10'($urandom);
      i_sprite_y     = N*10'($urandom);
      i_sprite_en    = N'($urandom);
      i_sprite_color = N*8'($urandom);
   endtask

   task automatic do_frame(input int x0, input int y0, input int x1, input int y1,
                           input bit [1:0] en, input int c0, input int c1,
                           input bit abort, input bit start_on_done);
      int t, idx, done_cyc;
      int sx[N], sy[N], sc[N];
      exp_t e;
      @(posedge clk); #1;
      sx[0] = x0; sy[0] = y0; sc[0] = c0;
      sx[1] = x1; sy[1] = y1; sc[1] = c1;
      for (int k = 0; k < N; k++) begin
         i_sprite_x[k*10 +: 10]   = 10'(sx[k]);
         i_sprite_y[k*10 +: 10]   = 10'(sy[k]);
         i_sprite_color[k*8 +: 8] = 8'(sc[k]);
         f_x[k] = sx[k]; f_y[k] = sy[k]; f_col[k] = sc[k]; f_en[k] = en[k];
      end
      i_sprite_en = en;
      i_start = 1'b1;
      t = cyc;
      idx = t + 1;
      if (CLR)
         for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
               e = '{idx, 1'b1, 1'b1, y*H + x, int'(BG), 1'b0};
               q.push_back(e);
               idx++;
            end
      for (int k = 0; k < N; k++)
         for (int dy = 0; dy < SH; dy++)
            for (int dx = 0; dx < SW; dx++) begin
               int px, py;
               bit w;
               px = sx[k] + dx;
               py = sy[k] + dy;
               w  = en[k] && px < H && py < V;
               e  = '{idx, 1'b1, w, w ? py*H + px : 0, w ? sc[k] : 0, 1'b0};
               q.push_back(e);
               idx++;
            end
      done_cyc = idx;
      e = '{done_cyc, 1'b0, 1'b0, 0, 0, 1'b1};
      q.push_back(e);
      while (cyc < done_cyc) begin
         @(posedge clk); #1;
         scramble();
         i_start = (cyc == done_cyc) ? start_on_done : ($urandom_range(0, 5) == 0);
         if (abort && cyc == t + 20) begin
            i_r = 1'b1;
            i_start = 1'b0;
            q.delete();
            for (int p = 0; p < H*V; p++) fb_known[p] = 1'b0;
            #1;
            chk("reset_drops_we", o_we, 0);
            chk("reset_drops_busy", o_busy, 0);
            @(posedge clk); #1;
            i_r = 1'b0;
            break;
         end
      end
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      i_r = 1'b1;
      i_start = 1'b0;
      i_sprite_x = '0; i_sprite_y = '0; i_sprite_en = '0; i_sprite_color = '0;
      for (int p = 0; p < H*V; p++) begin
         fb_dut[p] = 0; fb_exp[p] = 0; fb_known[p] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 i_r = 1'b0;
      repeat (10) @(posedge clk);

      do_frame(0, 0, 0, 0, 2'b00, 8'h11, 8'h22, 1'b0, 1'b0);
      do_frame(1, 1, 0, 0, 2'b01, 8'h03, 8'h22, 1'b0, 1'b0);
      do_frame(7, 3, 0, 0, 2'b01, 8'h03, 8'h22, 1'b0, 1'b0);
      do_frame(2, 0, 2, 0, 2'b11, 8'h03, 8'h1C, 1'b0, 1'b0);
      do_frame(3, 1, 6, 2, 2'b11, 8'h45, 8'h67, 1'b1, 1'b0);
      do_frame(0, 0, 5, 3, 2'b11, 8'h0F, 8'hF0, 1'b0, 1'b1);
      do_frame(4, 2, 1, 0, 2'b10, 8'h99, 8'hAA, 1'b0, 1'b1);
      for (int i = 0; i < 25; i++)
         do_frame($urandom_range(0, 9), $urandom_range(0, 5),
                  $urandom_range(0, 9), $urandom_range(0, 5),
                  2'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);

      repeat (5) @(posedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised frame-buffer writer. On each `start` pulse it optionally fills the whole frame with a background colour, then rasterises up to `NUM_SPR` solid-colour rectangular sprites into the frame buffer, one pixel write per clock. It sits between the game/sprite-position logic and the frame-buffer RAM write port, and is normally triggered once per vertical blank. It replaces the fixed single-sprite writer with configurable resolution, sprite size, sprite count, per-sprite colour and enable, screen-edge clipping, and a start/busy/done handshake.

## Interface
- `H_RES`, 640, frame width in pixels
- `V_RES`, 480, frame height in pixels
- `ADDR_W`, 19, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES
- `COLOR_W`, 8, pixel colour width
- `SPR_W`, 10, sprite width in pixels
- `SPR_H`, 10, sprite height in pixels
- `NUM_SPR`, 4, number of sprite slots
- `BG_COLOR`, 8'b1110_0000, background fill colour
- `clk`  in  1  system clock
- `r`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle request to draw a frame
- `sprite_x`  in  NUM_SPR×10  sprite top-left X, per slot
- `sprite_y`  in  NUM_SPR×10  sprite top-left Y, per slot
- `sprite_en`  in  NUM_SPR  slot enable
- `sprite_color`  in  NUM_SPR×COLOR_W  slot colour
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse when a frame completes
- `we`  out  1  frame-buffer write enable
- `addr`  out  ADDR_W  frame-buffer write address
- `color`  out  COLOR_W  frame-buffer write data

## Operation
- States: IDLE, CLEAR, SPRITE, FINISH.
- IDLE: `start`=1 → latch all `sprite_*` inputs into shadow registers. Go to CLEAR, or to SPRITE when the clear feature is compiled out.
- CLEAR: scan x 0..H_RES-1 (inner loop), y 0..V_RES-1 (outer loop). Write `BG_COLOR` at `addr = y·H_RES + x`. After the last pixel → SPRITE with slot 0.
- SPRITE: for slot k = 0..NUM_SPR-1, scan dx 0..SPR_W-1 (inner loop), dy 0..SPR_H-1 (outer loop). px = sx+dx and py = sy+dy, each computed 11 bits wide with no wrap.
  - `we`=1 only when the slot is enabled and px < H_RES and py < V_RES (clipping). Otherwise `we`=0.
  - A disabled slot still consumes SPR_W·SPR_H cycles, so frame latency is deterministic.
  - Higher slot index overwrites lower where sprites overlap.
- FINISH: one cycle. `done`=1, then → IDLE.
- `start` while not IDLE is ignored. Shadow registers hold their values across the whole frame; input changes mid-frame have no effect.
- Address arithmetic is done at ADDR_W width. When `we`=0, `addr` and `color` are don't-care but are driven to 0.

## Timing
- Reset values: state IDLE; `busy`, `done`, `we` = 0; `addr`, `color` = 0; all counters and shadow registers 0.
- All outputs are registered.
- Start is sampled in cycle T. The first write appears on `we`/`addr`/`color` in cycle T+1. `busy`=1 from T+1 through the last write cycle.
- Write cycles = H_RES·V_RES (clear) + NUM_SPR·SPR_W·SPR_H. `done` is high in the cycle after the last write, with `busy`=0 in that cycle.
- There is no write backpressure: the RAM port must accept one write per clock.
- `start` in the same cycle as `done` is ignored. The earliest accepted restart is the cycle after `done`.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronously), with no partial `done`.

## Configuration
- `SPRITE_BLITTER_CLEAR_EN` defined: the CLEAR pass is compiled in, as described above.
- Not defined: IDLE goes straight to SPRITE. Only sprite pixels are written, the previous frame content persists, and latency drops by H_RES·V_RES cycles.

## Structure
- Shared package `blitter_pkg`: state enum typedef, default resolution constants (640/480), address-width constant, and the background colour constant.
- One sub-module, `rect_scan`: a parametrised 2-D x/y counter.
  - Inputs: width, height, `step`.
  - Outputs: x, y, `last`.
  - Instantiated once and reloaded with H_RES/V_RES for the CLEAR pass and with SPR_W/SPR_H for each sprite slot.

## Test plan
All scenarios use H_RES=8, V_RES=4, SPR_W=SPR_H=2, NUM_SPR=2, with the clear feature enabled unless stated.
- Reset, then idle 10 cycles → `we`, `busy`, `done` stay 0; `addr`=0.
- Start with both slots disabled → 32 writes of `BG_COLOR` at addresses 0..31 in order, then 8 cycles with `we`=0; `done` pulses at cycle T+41.
- Slot 0 at (1,1), colour 0x03 → writes to 9, 10, 17, 18 after the clear pass; `done` pulses exactly once.
- Slot 0 at (7,3) → only address 31 is written; the other 3 sprite cycles have `we`=0 (clipping).
- Slots 0 and 1 both at (2,0), colours 0x03 and 0x1C → address 2 is written 0x03, then later 0x1C (last write wins).
- Assert `r` at cycle T+20 → `we`/`busy` drop immediately and no `done` occurs. A new `start` then restarts at address 0.
- Clear feature compiled out, one sprite enabled → first write is sprite pixel 0 at T+1; `done` pulses at T+9.
